// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared constants and helpers for the EX-stage iterative divider.
//   - RV32M opcode/funct7 and the divide funct3 codes that EX decodes
//   - FSM state encoding of the divider
//   - hold level that EX maps hold_req_o onto in the hold controller
//   - small helpers for op decoding and two's-complement handling
package ex_div_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  // Last CALC iteration index; CALC runs for counts 0 .. ITER-1.
  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  // M-extension decode constants used by EX.
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Hold level EX requests from the hold controller while dividing.
  localparam logic [2:0] HOLD_EX = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_CALC  = 2'b10,
    ST_END   = 2'b11
  } div_state_e;

  // True for the four divide/remainder funct3 codes.
  function automatic logic is_div_op(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_DIV, F3_DIVU, F3_REM, F3_REMU: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // DIV and REM are the signed variants (funct3[0] clear).
  function automatic logic is_signed_op(input logic [2:0] f3);
    return ~f3[0];
  endfunction

  // REM and REMU return the remainder (funct3[1] set).
  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[1];
  endfunction

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of v when treated as signed; unsigned ops pass v through.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                              input logic sgn);
    logic [XLEN-1:0] r;
    if (sgn && v[XLEN-1]) begin
      r = twos_neg(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// ex_div_if: request/response bundle between EX (master) and the divider (slave).
//   master drives start_i, op_i, dividend_i, divisor_i, reg_wr_addr_i, flush_i
//   slave  drives busy_o, hold_req_o, ready_o, result_o, reg_wr_addr_o
interface ex_div_if;
  import ex_div_pkg::*;

  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      reg_wr_addr_i;
  logic            flush_i;

  logic            busy_o;
  logic            hold_req_o;
  logic            ready_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      reg_wr_addr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_wr_addr_i, flush_i,
    input  busy_o, hold_req_o, ready_o, result_o, reg_wr_addr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_wr_addr_i, flush_i,
    output busy_o, hold_req_o, ready_o, result_o, reg_wr_addr_o
  );

endinterface

// File: rtl/ex_div.sv
// ex_div: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous active-high reset
//   div_if - ex_div_if.slave: start/op/operands/rd/flush in;
//            busy/hold_req/ready/result/rd out
// One quotient bit per CALC cycle; ready_o pulses ITER+2 edges after the
// start edge (2 edges for a zero divisor). hold_req_o is combinational so
// EX stalls in the very cycle the divide instruction arrives.
module ex_div
  import ex_div_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  div_if
);

  div_state_e      state_r;
  div_state_e      state_n_s;

  logic [2:0]      op_r;
  logic [XLEN-1:0] dividend_r;
  logic [XLEN-1:0] divisor_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] dvd_r;
  logic [XLEN-1:0] dsr_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quot_r;
  logic [4:0]      count_r;
  logic            neg_q_r;
  logic            neg_r_r;

  logic            ready_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      rd_out_r;

  logic            accept_s;
  logic            hold_req_s;
  logic [XLEN:0]   rem_shift_s;
  logic [XLEN-1:0] diff_s;
  logic            qbit_s;
  logic [XLEN-1:0] final_s;

  assign accept_s = div_if.start_i & is_div_op(div_if.op_i) & ~div_if.flush_i;

  // One restoring step. The partial remainder is always below the divisor,
  // so the 33-bit shifted value only exceeds 32 bits through its MSB; the
  // 33-bit compare is that MSB OR'd with the low 32-bit compare, and the
  // true difference always fits back in 32 bits.
  always_comb begin
    rem_shift_s = {rem_r, dvd_r[XLEN-1]};
    diff_s      = rem_shift_s[XLEN-1:0] - dsr_r;
    qbit_s      = rem_shift_s[XLEN] | (rem_shift_s[XLEN-1:0] >= dsr_r);
  end

  // Final result selection with sign correction.
  always_comb begin
    final_s = '0;
    if (is_rem_op(op_r)) begin
      final_s = neg_r_r ? twos_neg(rem_r) : rem_r;
    end else begin
      final_s = neg_q_r ? twos_neg(quot_r) : quot_r;
    end
  end

  // Next-state and stall request; flush wins over everything but reset.
  always_comb begin
    state_n_s  = state_r;
    hold_req_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_n_s  = ST_START;
          hold_req_s = 1'b1;
        end else begin
          state_n_s  = ST_IDLE;
        end
      end
      ST_START: begin
        if (div_if.flush_i) begin
          state_n_s = ST_IDLE;
        end else if (divisor_r == 32'd0) begin
          state_n_s  = ST_END;
          hold_req_s = 1'b1;
        end else begin
          state_n_s  = ST_CALC;
          hold_req_s = 1'b1;
        end
      end
      ST_CALC: begin
        if (div_if.flush_i) begin
          state_n_s = ST_IDLE;
        end else if (count_r == LAST_CNT) begin
          state_n_s  = ST_END;
          hold_req_s = 1'b1;
        end else begin
          state_n_s  = ST_CALC;
          hold_req_s = 1'b1;
        end
      end
      ST_END: begin
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= 3'b000;
      dividend_r <= 32'd0;
      divisor_r  <= 32'd0;
      rd_r       <= 5'd0;
      dvd_r      <= 32'd0;
      dsr_r      <= 32'd0;
      rem_r      <= 32'd0;
      quot_r     <= 32'd0;
      count_r    <= 5'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      ready_r    <= 1'b0;
      result_r   <= 32'd0;
      rd_out_r   <= 5'd0;
    end else begin
      ready_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r       <= div_if.op_i;
            dividend_r <= div_if.dividend_i;
            divisor_r  <= div_if.divisor_i;
            rd_r       <= div_if.reg_wr_addr_i;
          end else begin
            op_r <= op_r;
          end
        end
        ST_START: begin
          count_r <= 5'd0;
          if (divisor_r == 32'd0) begin
            // Zero divisor: quotient all ones, remainder is the dividend.
            quot_r  <= 32'hFFFF_FFFF;
            rem_r   <= dividend_r;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
          end else begin
            dvd_r   <= abs_val(dividend_r, is_signed_op(op_r));
            dsr_r   <= abs_val(divisor_r, is_signed_op(op_r));
            rem_r   <= 32'd0;
            quot_r  <= 32'd0;
            neg_q_r <= is_signed_op(op_r) & (dividend_r[XLEN-1] ^ divisor_r[XLEN-1]);
            neg_r_r <= is_signed_op(op_r) & dividend_r[XLEN-1];
          end
        end
        ST_CALC: begin
          rem_r   <= qbit_s ? diff_s : rem_shift_s[XLEN-1:0];
          dvd_r   <= {dvd_r[XLEN-2:0], 1'b0};
          quot_r  <= {quot_r[XLEN-2:0], qbit_s};
          count_r <= count_r + 5'd1;
        end
        ST_END: begin
          // A flush seen on the END edge drops the result entirely.
          if (!div_if.flush_i) begin
            ready_r  <= 1'b1;
            result_r <= final_s;
            rd_out_r <= rd_r;
          end else begin
            ready_r  <= 1'b0;
          end
        end
        default: begin
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign div_if.busy_o        = (state_r != ST_IDLE);
  assign div_if.hold_req_o    = hold_req_s;
  assign div_if.ready_o       = ready_r;
  assign div_if.result_o      = result_r;
  assign div_if.reg_wr_addr_o = rd_out_r;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: table-driven check of ex_div plus directed flush/reset/busy sequences.
module tb_ex_div;
  import ex_div_pkg::*;

  logic clk;
  logic rst;

  ex_div_if dif ();

  ex_div u_dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one divide and wait (bounded) for ready_o.
  task automatic do_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int holds,
                        output logic [31:0] res, output logic [4:0] rdo);
    logic got;
    got   = 1'b0;
    lat   = -1;
    holds = 0;
    res   = 32'd0;
    rdo   = 5'd0;
    @(negedge clk);
    dif.start_i       = 1'b1;
    dif.op_i          = op;
    dif.dividend_i    = a;
    dif.divisor_i     = b;
    dif.reg_wr_addr_i = rd;
    #1;
    if (dif.hold_req_o) holds++;
    @(posedge clk);
    #1;
    dif.start_i = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (dif.ready_o) begin
        got = 1'b1;
        lat = k;
        res = dif.result_o;
        rdo = dif.reg_wr_addr_o;
      end else if (dif.hold_req_o) begin
        holds++;
      end
    end
  endtask

  // Count ready pulses over n cycles.
  task automatic count_ready(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (dif.ready_o) cnt++;
    end
  endtask

  initial begin
    int lat;
    int holds;
    int cnt;
    logic [31:0] res;
    logic [4:0]  rdo;

    checks = 0;
    errors = 0;

    vecs[0]  = '{F3_DIVU, 32'd100,        32'd7,        5'd5,  32'd14,        34};
    vecs[1]  = '{F3_REMU, 32'd100,        32'd7,        5'd6,  32'd2,         34};
    vecs[2]  = '{F3_REM,  32'hFFFF_FFF9,  32'd2,        5'd7,  32'hFFFF_FFFF, 34};
    vecs[3]  = '{F3_DIV,  32'hFFFF_FFF9,  32'd2,        5'd8,  32'hFFFF_FFFD, 34};
    vecs[4]  = '{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 34};
    vecs[5]  = '{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'd0,         34};
    vecs[6]  = '{F3_DIVU, 32'd5,          32'd0,        5'd11, 32'hFFFF_FFFF, 2};
    vecs[7]  = '{F3_REMU, 32'd5,          32'd0,        5'd12, 32'd5,         2};
    vecs[8]  = '{F3_DIV,  32'd7,          32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 34};
    vecs[9]  = '{F3_REM,  32'd7,          32'hFFFF_FFFE, 5'd14, 32'd1,         34};
    vecs[10] = '{F3_DIVU, 32'hFFFF_FFFF,  32'd1,        5'd15, 32'hFFFF_FFFF, 34};
    vecs[11] = '{F3_DIV,  32'hFFFF_FFF9,  32'd0,        5'd16, 32'hFFFF_FFFF, 2};
    vecs[12] = '{F3_REM,  32'hFFFF_FFF9,  32'd0,        5'd17, 32'hFFFF_FFF9, 2};
    vecs[13] = '{F3_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'd0,         34};
    vecs[14] = '{F3_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 34};
    vecs[15] = '{F3_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 5'd31, 32'hFFFF_FFFF, 34};

    dif.start_i       = 1'b0;
    dif.op_i          = 3'b000;
    dif.dividend_i    = 32'd0;
    dif.divisor_i     = 32'd0;
    dif.reg_wr_addr_i = 5'd0;
    dif.flush_i       = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    check("reset_busy",   {31'd0, dif.busy_o},     32'd0);
    check("reset_ready",  {31'd0, dif.ready_o},    32'd0);
    check("reset_hold",   {31'd0, dif.hold_req_o}, 32'd0);
    check("reset_result", dif.result_o,            32'd0);
    check("reset_rd",     {27'd0, dif.reg_wr_addr_o}, 32'd0);

    // Invalid funct3 never starts.
    @(negedge clk);
    dif.start_i = 1'b1;
    dif.op_i    = 3'b001;
    #1;
    check("badop_hold", {31'd0, dif.hold_req_o}, 32'd0);
    @(posedge clk);
    #1;
    check("badop_busy", {31'd0, dif.busy_o}, 32'd0);
    dif.start_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_div(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat, holds, res, rdo);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_rd", i), {27'd0, rdo}, {27'd0, vecs[i].rd});
      check($sformatf("vec%0d_hold_cycles", i), 32'(holds), 32'(vecs[i].exp_lat));
    end

    // Result holds after the ready pulse.
    repeat (3) @(posedge clk);
    #1;
    check("result_holds", dif.result_o, 32'hFFFF_FFFF);
    check("ready_single", {31'd0, dif.ready_o}, 32'd0);

    // Flush at CALC count 10: start edge E0, count 10 after E11.
    @(negedge clk);
    dif.start_i    = 1'b1;
    dif.op_i       = F3_DIV;
    dif.dividend_i = 32'd100;
    dif.divisor_i  = 32'd7;
    @(posedge clk);
    #1;
    dif.start_i = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    dif.flush_i = 1'b1;
    #1;
    check("flush_hold_same_cycle", {31'd0, dif.hold_req_o}, 32'd0);
    check("flush_busy_before", {31'd0, dif.busy_o}, 32'd1);
    @(posedge clk);
    #1;
    dif.flush_i = 1'b0;
    check("flush_busy_after", {31'd0, dif.busy_o}, 32'd0);
    count_ready(40, cnt);
    check("flush_no_ready", 32'(cnt), 32'd0);
    do_div(F3_DIV, 32'd9, 32'd3, 5'd4, lat, holds, res, rdo);
    check("after_flush_result", res, 32'd3);
    check("after_flush_latency", 32'(lat), 32'd34);

    // Flush has priority over start in IDLE.
    @(negedge clk);
    dif.start_i = 1'b1;
    dif.op_i    = F3_DIVU;
    dif.flush_i = 1'b1;
    #1;
    check("idle_flush_hold", {31'd0, dif.hold_req_o}, 32'd0);
    @(posedge clk);
    #1;
    dif.start_i = 1'b0;
    dif.flush_i = 1'b0;
    check("idle_flush_busy", {31'd0, dif.busy_o}, 32'd0);

    // Reset pulsed mid-CALC.
    @(negedge clk);
    dif.start_i    = 1'b1;
    dif.op_i       = F3_DIVU;
    dif.dividend_i = 32'd100;
    dif.divisor_i  = 32'd7;
    dif.reg_wr_addr_i = 5'd21;
    @(posedge clk);
    #1;
    dif.start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy",   {31'd0, dif.busy_o},     32'd0);
    check("rst_mid_ready",  {31'd0, dif.ready_o},    32'd0);
    check("rst_mid_hold",   {31'd0, dif.hold_req_o}, 32'd0);
    check("rst_mid_result", dif.result_o,            32'd0);
    check("rst_mid_rd",     {27'd0, dif.reg_wr_addr_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_ready(40, cnt);
    check("rst_no_ready", 32'(cnt), 32'd0);

    // start_i held while busy: exactly one result.
    @(negedge clk);
    dif.start_i       = 1'b1;
    dif.op_i          = F3_DIVU;
    dif.dividend_i    = 32'd100;
    dif.divisor_i     = 32'd7;
    dif.reg_wr_addr_i = 5'd22;
    cnt = 0;
    res = 32'd0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 20) dif.start_i = 1'b0;
      if (dif.ready_o) begin
        cnt++;
        res = dif.result_o;
      end
    end
    check("held_start_ready_count", 32'(cnt), 32'd1);
    check("held_start_result", res, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
